// File: rtl/jtag_tap_sync.sv
// -----------------------------------------------------------------------------
// jtag_tap_sync
//
// IEEE 1149.1 TAP controller running entirely in the system clock domain.
// The pad-level TCK/TMS/TDI are oversampled through two-flop synchronizers and
// a third TCK flop provides rise/fall edge pulses; every TAP action happens on
// a wb_clk_i edge qualified by one of those pulses. Provides IDCODE and BYPASS
// data registers locally and a strobe-based DR port for the debug interface.
//
// Ports
//   wb_clk_i        system clock (the only clock)
//   wb_rst_i        asynchronous active-high reset
//   tck_pad_i       JTAG TCK pad (asynchronous, oversampled)
//   tms_pad_i       JTAG TMS pad
//   tdi_pad_i       JTAG TDI pad
//   tdo_pad_o       JTAG TDO pad, updated on synchronized TCK fall
//   debug_select_o  active IR holds DEBUG
//   capture_dr_o    one-cycle strobe: Capture-DR left with DEBUG selected
//   shift_dr_o      one-cycle strobe: Shift-DR TCK rise with DEBUG selected
//   update_dr_o     one-cycle strobe: Update-DR entered with DEBUG selected
//   tdi_o           synchronized TDI, valid with shift_dr_o
//   debug_tdo_i     debug DR serial output, sampled on the TCK fall
//
// State table
//   state        | meaning
//   ST_TLR       | Test-Logic-Reset, IR forced to IDCODE
//   ST_RTI       | Run-Test/Idle
//   ST_SEL_DR    | Select-DR-Scan
//   ST_CAP_DR    | Capture-DR, selected DR loaded on leaving
//   ST_SHIFT_DR  | Shift-DR, selected DR shifts on each TCK rise
//   ST_EXIT1_DR  | Exit1-DR
//   ST_PAUSE_DR  | Pause-DR, DR held
//   ST_EXIT2_DR  | Exit2-DR
//   ST_UPD_DR    | Update-DR
//   ST_SEL_IR    | Select-IR-Scan
//   ST_CAP_IR    | Capture-IR, IR shift register loaded with 4'b0101
//   ST_SHIFT_IR  | Shift-IR
//   ST_EXIT1_IR  | Exit1-IR
//   ST_PAUSE_IR  | Pause-IR, IR shift register held
//   ST_EXIT2_IR  | Exit2-IR
//   ST_UPD_IR    | Update-IR, active IR loaded on entry
// -----------------------------------------------------------------------------
module jtag_tap_sync #(
    parameter logic [31:0] IDCODE_VALUE = 32'h149511c3,
    // Instruction decode below assumes 4 bits; kept as a parameter for
    // readability only.
    parameter int          IR_WIDTH     = 4
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic tck_pad_i,
    input  logic tms_pad_i,
    input  logic tdi_pad_i,
    output logic tdo_pad_o,
    output logic debug_select_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic update_dr_o,
    output logic tdi_o,
    input  logic debug_tdo_i
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(4'b0010);
    localparam logic [IR_WIDTH-1:0] IR_DEBUG   = IR_WIDTH'(4'b1000);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(4'b0101);

    typedef enum logic [3:0] {
        ST_TLR,
        ST_RTI,
        ST_SEL_DR,
        ST_CAP_DR,
        ST_SHIFT_DR,
        ST_EXIT1_DR,
        ST_PAUSE_DR,
        ST_EXIT2_DR,
        ST_UPD_DR,
        ST_SEL_IR,
        ST_CAP_IR,
        ST_SHIFT_IR,
        ST_EXIT1_IR,
        ST_PAUSE_IR,
        ST_EXIT2_IR,
        ST_UPD_IR
    } tap_state_e;

    tap_state_e state_q, state_d;
    tap_state_e state_nxt;

    // Synchronizers: bit 0 is the first sampling flop.
    logic [2:0] tck_sync_q, tck_sync_d;
    logic [1:0] tms_sync_q, tms_sync_d;
    logic [1:0] tdi_sync_q, tdi_sync_d;
    logic [1:0] sync_fill_q, sync_fill_d;
    logic       tck_armed_q, tck_armed_d;

    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [31:0]         id_sr_q, id_sr_d;
    logic                bypass_q, bypass_d;
    logic                tdo_q, tdo_d;
    logic                tdi_out_q, tdi_out_d;
    logic                capture_q, capture_d;
    logic                shift_q, shift_d;
    logic                update_q, update_d;

    logic tck_rise;
    logic tck_fall;
    logic tms_s;
    logic tdi_s;
    logic sel_idcode;
    logic sel_debug;
    logic sel_bypass;
    logic dr_serial;

    assign tms_s = tms_sync_q[1];
    assign tdi_s = tdi_sync_q[1];

    // The synchronizer resets to 0, so a TCK held high through reset release
    // would otherwise look like a rise. A rise is only honoured once a real
    // low sample has been seen at the second synchronizer stage.
    assign tck_rise = tck_sync_q[1] & ~tck_sync_q[2] & tck_armed_q;
    assign tck_fall = ~tck_sync_q[1] & tck_sync_q[2];

    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_debug  = (ir_q == IR_DEBUG);
    assign sel_bypass = ~sel_idcode & ~sel_debug;

    always_comb begin
        dr_serial = bypass_q;
        if (sel_idcode) begin
            dr_serial = id_sr_q[0];
        end else if (sel_debug) begin
            dr_serial = debug_tdo_i;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_TLR:      state_nxt = tms_s ? ST_TLR      : ST_RTI;
            ST_RTI:      state_nxt = tms_s ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_nxt = tms_s ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_nxt = tms_s ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: state_nxt = tms_s ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: state_nxt = tms_s ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_nxt = tms_s ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: state_nxt = tms_s ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   state_nxt = tms_s ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_nxt = tms_s ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_nxt = tms_s ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: state_nxt = tms_s ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: state_nxt = tms_s ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_nxt = tms_s ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: state_nxt = tms_s ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   state_nxt = tms_s ? ST_SEL_DR   : ST_RTI;
            default:     state_nxt = ST_TLR;
        endcase
        state_d = tck_rise ? state_nxt : state_q;
    end

    // -------------------------------------------------------------------------
    // Datapath / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        tck_sync_d  = {tck_sync_q[1:0], tck_pad_i};
        tms_sync_d  = {tms_sync_q[0], tms_pad_i};
        tdi_sync_d  = {tdi_sync_q[0], tdi_pad_i};
        sync_fill_d = {sync_fill_q[0], 1'b1};
        tck_armed_d = tck_armed_q | (sync_fill_q[1] & ~tck_sync_q[1]);

        ir_d      = ir_q;
        ir_sr_d   = ir_sr_q;
        id_sr_d   = id_sr_q;
        bypass_d  = bypass_q;
        tdo_d     = tdo_q;
        tdi_out_d = tdi_out_q;
        capture_d = 1'b0;
        shift_d   = 1'b0;
        update_d  = 1'b0;

        if (tck_rise) begin
            case (state_q)
                ST_CAP_IR: begin
                    ir_sr_d = IR_CAPTURE;
                end
                ST_SHIFT_IR: begin
                    ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
                end
                ST_CAP_DR: begin
                    if (sel_idcode) begin
                        id_sr_d = IDCODE_VALUE;
                    end
                    if (sel_bypass) begin
                        bypass_d = 1'b0;
                    end
                    capture_d = sel_debug;
                end
                ST_SHIFT_DR: begin
                    if (sel_idcode) begin
                        id_sr_d = {tdi_s, id_sr_q[31:1]};
                    end
                    if (sel_bypass) begin
                        bypass_d = tdi_s;
                    end
                    if (sel_debug) begin
                        shift_d   = 1'b1;
                        tdi_out_d = tdi_s;
                    end
                end
                default: begin
                end
            endcase

            // Update actions fire on entry; the shift register is not touched
            // on this rise because state_q is an Exit state.
            if (state_d == ST_UPD_IR) begin
                ir_d = ir_sr_q;
            end
            if (state_d == ST_UPD_DR) begin
                update_d = sel_debug;
            end
            if (state_d == ST_TLR) begin
                ir_d = IR_IDCODE;
            end
        end

        if (tck_fall) begin
            if (state_q == ST_SHIFT_IR) begin
                tdo_d = ir_sr_q[0];
            end else if (state_q == ST_SHIFT_DR) begin
                tdo_d = dr_serial;
            end else begin
                tdo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
            sync_fill_q <= '0;
            tck_armed_q <= 1'b0;
            ir_q        <= IR_IDCODE;
            ir_sr_q     <= '0;
            id_sr_q     <= '0;
            bypass_q    <= 1'b0;
            tdo_q       <= 1'b0;
            tdi_out_q   <= 1'b0;
            capture_q   <= 1'b0;
            shift_q     <= 1'b0;
            update_q    <= 1'b0;
        end else begin
            tck_sync_q  <= tck_sync_d;
            tms_sync_q  <= tms_sync_d;
            tdi_sync_q  <= tdi_sync_d;
            sync_fill_q <= sync_fill_d;
            tck_armed_q <= tck_armed_d;
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            id_sr_q     <= id_sr_d;
            bypass_q    <= bypass_d;
            tdo_q       <= tdo_d;
            tdi_out_q   <= tdi_out_d;
            capture_q   <= capture_d;
            shift_q     <= shift_d;
            update_q    <= update_d;
        end
    end

    assign tdo_pad_o      = tdo_q;
    assign debug_select_o = sel_debug;
    assign capture_dr_o   = capture_q;
    assign shift_dr_o     = shift_q;
    assign update_dr_o    = update_q;
    assign tdi_o          = tdi_out_q;

endmodule

// File: tb/tb_jtag_tap_sync.sv
module tb_jtag_tap_sync;

    localparam logic [31:0] IDCODE = 32'h149511c3;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    logic tck = 1'b0;
    logic tms = 1'b0;
    logic tdi = 1'b0;
    logic tdo_pad_o;
    logic debug_select_o;
    logic capture_dr_o;
    logic shift_dr_o;
    logic update_dr_o;
    logic tdi_o;
    logic debug_tdo_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Debug-side model: a small DR that captures 8'h96 and shifts right with
    // tdi_o entering the MSB on each shift strobe.
    logic [7:0] dbg_sr = 8'h00;
    int         cnt_cap = 0;
    int         cnt_shift = 0;
    int         cnt_upd = 0;
    int         multi_strobe = 0;
    logic       tdi_log[$];

    assign debug_tdo_i = dbg_sr[0];

    always #5 wb_clk_i = ~wb_clk_i;

    jtag_tap_sync dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .tck_pad_i      (tck),
        .tms_pad_i      (tms),
        .tdi_pad_i      (tdi),
        .tdo_pad_o      (tdo_pad_o),
        .debug_select_o (debug_select_o),
        .capture_dr_o   (capture_dr_o),
        .shift_dr_o     (shift_dr_o),
        .update_dr_o    (update_dr_o),
        .tdi_o          (tdi_o),
        .debug_tdo_i    (debug_tdo_i)
    );

    always @(negedge wb_clk_i) begin
        if ((int'(capture_dr_o) + int'(shift_dr_o) + int'(update_dr_o)) > 1)
            multi_strobe++;
        if (capture_dr_o) begin
            cnt_cap++;
            dbg_sr <= 8'h96;
        end
        if (shift_dr_o) begin
            cnt_shift++;
            tdi_log.push_back(tdi_o);
            dbg_sr <= {tdi_o, dbg_sr[7:1]};
        end
        if (update_dr_o)
            cnt_upd++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
        @(negedge wb_clk_i);
        tms = tms_v;
        tdi = tdi_v;
        @(negedge wb_clk_i);
        tck = 1'b1;
        repeat (5) @(negedge wb_clk_i);
        tck = 1'b0;
        repeat (5) @(negedge wb_clk_i);
        tdo_v = tdo_pad_o;
    endtask

    // Full scan starting and ending in Run-Test/Idle. dout[0] is the bit
    // presented on entering Shift, dout[i+1] the bit after shift i.
    task automatic scan(input logic is_ir, input int n, input logic [63:0] din,
                        output logic [63:0] dout);
        logic b;
        dout = '0;
        tck_cycle(1'b1, 1'b0, b);
        if (is_ir) tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        dout[0] = b;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], b);
            if (i < n - 1) dout[i+1] = b;
        end
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
    endtask

    typedef struct {
        string       name;
        logic        is_ir;
        int          nbits;
        logic [63:0] din;
        logic [63:0] exp_dout;
        int          exp_cap;
        int          exp_shift;
        int          exp_upd;
        logic        exp_dsel;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [63:0] dout;
        logic        b;
        logic        tdo_or;
        int          c0, s0, u0, base;
        logic [63:0] got_tdi;

        vecs[0] = '{"idcode1",    1'b0, 32, 64'h0,   64'(IDCODE), 0, 0, 0, 1'b0};
        vecs[1] = '{"idcode2",    1'b0, 32, 64'h0,   64'(IDCODE), 0, 0, 0, 1'b0};
        vecs[2] = '{"ir_debug",   1'b1, 4,  64'h8,   64'h5,       0, 0, 0, 1'b1};
        vecs[3] = '{"dr_debug",   1'b0, 8,  64'h3C,  64'h96,      1, 8, 1, 1'b1};
        vecs[4] = '{"ir_1111",    1'b1, 4,  64'hF,   64'h5,       0, 0, 0, 1'b0};
        vecs[5] = '{"bypass_a5",  1'b0, 9,  64'h0A5, 64'h14A,     0, 0, 0, 1'b0};
        vecs[6] = '{"ir_0011",    1'b1, 4,  64'h3,   64'h5,       0, 0, 0, 1'b0};
        vecs[7] = '{"bypass_5a",  1'b0, 9,  64'h05A, 64'h0B4,     0, 0, 0, 1'b0};
        vecs[8] = '{"ir_idcode",  1'b1, 4,  64'h2,   64'h5,       0, 0, 0, 1'b0};
        vecs[9] = '{"idcode3",    1'b0, 32, 64'h0,   64'(IDCODE), 0, 0, 0, 1'b0};

        // Reset with TCK idle
        repeat (3) @(negedge wb_clk_i);
        check("rst_tdo",     64'(tdo_pad_o),      64'h0);
        check("rst_dsel",    64'(debug_select_o), 64'h0);
        check("rst_cap",     64'(capture_dr_o),   64'h0);
        check("rst_shift",   64'(shift_dr_o),     64'h0);
        check("rst_upd",     64'(update_dr_o),    64'h0);
        check("rst_tdi_o",   64'(tdi_o),          64'h0);
        wb_rst_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);

        tdo_or = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tck_cycle(1'b0, 1'b1, b);
            tdo_or |= b;
        end
        check("idle_tdo",     64'(tdo_or),  64'h0);
        check("idle_strobes", 64'(cnt_cap + cnt_shift + cnt_upd), 64'h0);

        // Table-driven scans, each from and back to Run-Test/Idle
        for (int v = 0; v < 10; v++) begin
            c0 = cnt_cap;
            s0 = cnt_shift;
            u0 = cnt_upd;
            base = tdi_log.size();
            scan(vecs[v].is_ir, vecs[v].nbits, vecs[v].din, dout);
            check({vecs[v].name, "_tdo"},   dout, vecs[v].exp_dout);
            check({vecs[v].name, "_dsel"},  64'(debug_select_o), 64'(vecs[v].exp_dsel));
            check({vecs[v].name, "_ncap"},  64'(cnt_cap - c0),   64'(vecs[v].exp_cap));
            check({vecs[v].name, "_nshift"},64'(cnt_shift - s0), 64'(vecs[v].exp_shift));
            check({vecs[v].name, "_nupd"},  64'(cnt_upd - u0),   64'(vecs[v].exp_upd));
            if (vecs[v].exp_shift > 0) begin
                got_tdi = '0;
                for (int i = 0; i < vecs[v].nbits && base + i < tdi_log.size(); i++)
                    got_tdi[i] = tdi_log[base + i];
                check({vecs[v].name, "_tdi_o"}, got_tdi, vecs[v].din);
            end
        end
        check("multi_strobe", 64'(multi_strobe), 64'h0);

        // Forced TLR from Shift-DR with DEBUG selected
        scan(1'b1, 4, 64'h8, dout);
        check("ftlr_dsel_before", 64'(debug_select_o), 64'h1);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, b);
        check("ftlr_dsel_after", 64'(debug_select_o), 64'h0);
        check("ftlr_tdo",        64'(b),              64'h0);
        tck_cycle(1'b0, 1'b0, b);
        scan(1'b0, 32, 64'h0, dout);
        check("ftlr_idcode", dout, 64'(IDCODE));

        // Reset in the middle of an IDCODE shift, TCK high at release
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < 8; i++) tck_cycle(1'b0, 1'b0, b);
        check("mid_tdo_bit8", 64'(b), 64'(IDCODE[8]));
        @(negedge wb_clk_i);
        tms = 1'b0;
        @(negedge wb_clk_i);
        tck = 1'b1;
        repeat (4) @(negedge wb_clk_i);
        c0 = cnt_cap + cnt_shift + cnt_upd;
        wb_rst_i = 1'b1;
        #1;
        check("mid_rst_tdo",  64'(tdo_pad_o),      64'h0);
        check("mid_rst_dsel", 64'(debug_select_o), 64'h0);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (6) @(negedge wb_clk_i);
        tck = 1'b0;
        repeat (6) @(negedge wb_clk_i);
        check("mid_rst_strobes", 64'(cnt_cap + cnt_shift + cnt_upd - c0), 64'h0);
        // TMS=1 then 0 lands in Run-Test/Idle only if the FSM sat in TLR and
        // no spurious rise was taken at reset release.
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        scan(1'b0, 32, 64'h0, dout);
        check("mid_rst_idcode", dout, 64'(IDCODE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
